// File: rtl/lss_shift_seq.sv
// ============================================================================
// Module      : lss_shift_seq
// Description : Command sequencer for an lss_reg: load, N-bounded shifts, store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lss_shift_seq #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_data,
  input  logic          req_dir,
  input  logic          req_arith,
  input  logic [AW-1:0] req_amt,
  output logic [N-1:0]  reg_in,
  output logic [1:0]    reg_c,
  output logic          reg_clr,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam int XW = (AW > CW) ? AW : CW;

  localparam logic [1:0] c_C_STORE = 2'b00;
  localparam logic [1:0] c_C_LEFT  = 2'b01;
  localparam logic [1:0] c_C_LOAD  = 2'b10;
  localparam logic [1:0] c_C_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_amt;
  logic [N-1:0]   r_data;
  logic           r_dir;
  logic           r_fill;

  logic [XW-1:0]  w_amt_ext;
  logic [CW-1:0]  w_amt_sat;
  logic [CW-1:0]  w_count_nxt;
  logic           w_fill;

  // Compare in a width wide enough for both req_amt and N before saturating.
  assign w_amt_ext   = XW'(req_amt);
  assign w_amt_sat   = (w_amt_ext > XW'(N)) ? CW'(N) : CW'(w_amt_ext);
  assign w_count_nxt = r_count + CW'(1);
  assign w_fill      = req_dir & req_arith & req_data[N-1];

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_INIT;
      r_count   <= '0;
      r_amt     <= '0;
      r_data    <= '0;
      r_dir     <= 1'b0;
      r_fill    <= 1'b0;
      req_ready <= 1'b0;
      reg_c     <= c_C_STORE;
      reg_clr   <= 1'b0;
      reg_in    <= '0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state   <= S_IDLE;
          reg_clr   <= 1'b1;
          req_ready <= 1'b1;
        end
        S_IDLE: begin
          if (req_valid) begin
            r_state   <= S_LOAD;
            r_data    <= req_data;
            r_dir     <= req_dir;
            r_fill    <= w_fill;
            r_amt     <= w_amt_sat;
            r_count   <= '0;
            req_ready <= 1'b0;
            reg_c     <= c_C_LOAD;
            reg_in    <= req_data;
          end
        end
        S_LOAD: begin
          if (r_amt != '0) begin
            r_state <= S_SHIFT;
            reg_c   <= r_dir ? c_C_RIGHT : c_C_LEFT;
            reg_in  <= {N{r_fill}};
          end else begin
            r_state <= S_DONE;
            reg_c   <= c_C_STORE;
            reg_in  <= '0;
            done    <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_count <= w_count_nxt;
          if (w_count_nxt == r_amt) begin
            r_state <= S_DONE;
            reg_c   <= c_C_STORE;
            reg_in  <= '0;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_INIT;
          req_ready <= 1'b0;
          reg_c     <= c_C_STORE;
          reg_clr   <= 1'b0;
          reg_in    <= '0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
